rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 93 +++++++++
 tb/tb_rom_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester read arbiter in front of a 32-bit synchronous-read ROM.
// ROM_ARBITER_ROUND_ROBIN_EN selects round-robin; undefined gives fixed priority to requester 0.
module rom_arbiter #(
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  output logic                  o_req0_ready,
  output logic                  o_req0_rvalid,
  output logic [31:0]           o_req0_rdata,
  input  logic                  i_req1_valid,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  output logic                  o_req1_ready,
  output logic                  o_req1_rvalid,
  output logic [31:0]           o_req1_rdata,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [31:0]           i_rom_data
);

  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
  // last_q = 1 when requester 1 held the most recent grant
  logic last_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      gnt0 = i_req0_valid & (~i_req1_valid | last_q);
      gnt1 = i_req1_valid & (~i_req0_valid | ~last_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= 1'b1;
    end else if (gnt0) begin
      last_q <= 1'b0;
    end else if (gnt1) begin
      last_q <= 1'b1;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      gnt0 = i_req0_valid;
      gnt1 = i_req1_valid & ~i_req0_valid;
    end
  end
`endif

  // Idle cycles replay the last address so the ROM output stays put
  always_comb begin
    o_rom_addr = addr_q;
    if (gnt0) begin
      o_rom_addr = i_req0_addr;
    end else if (gnt1) begin
      o_rom_addr = i_req1_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0 | gnt1) begin
        addr_q <= o_rom_addr;
      end
    end
  end

  assign o_req0_ready  = gnt0;
  assign o_req1_ready  = gnt1;
  assign o_req0_rvalid = rvalid0_q;
  assign o_req1_rvalid = rvalid1_q;
  assign o_req0_rdata  = i_rom_data;
  assign o_req1_rdata  = i_rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scoreboard bench for rom_arbiter with a behavioural ROM.
// Contention expectations follow ROM_ARBITER_ROUND_ROBIN_EN when defined.
module tb_rom_arbiter;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);
  localparam int GNONE = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req0_valid;
  logic [AW-1:0] i_req0_addr;
  logic          o_req0_ready;
  logic          o_req0_rvalid;
  logic [31:0]   o_req0_rdata;
  logic          i_req1_valid;
  logic [AW-1:0] i_req1_addr;
  logic          o_req1_ready;
  logic          o_req1_rvalid;
  logic [31:0]   o_req1_rdata;
  logic [AW-1:0] o_rom_addr;
  logic [31:0]   i_rom_data;

  rom_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_addr  (i_req0_addr),
    .o_req0_ready (o_req0_ready),
    .o_req0_rvalid(o_req0_rvalid),
    .o_req0_rdata (o_req0_rdata),
    .i_req1_valid (i_req1_valid),
    .i_req1_addr  (i_req1_addr),
    .o_req1_ready (o_req1_ready),
    .o_req1_rvalid(o_req1_rvalid),
    .o_req1_rdata (o_req1_rdata),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [DEPTH];
  logic [31:0] rom_q;

  always_ff @(posedge i_clk) rom_q <= mem[o_rom_addr];
  assign i_rom_data = rom_q;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t          sbq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [AW-1:0] hold;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input exp_t e);
    chk({tag, " rvalid0"}, 32'(o_req0_rvalid), 32'(e.id == 0));
    chk({tag, " rvalid1"}, 32'(o_req1_rvalid), 32'(e.id == 1));
    if (e.id == 0) chk({tag, " rdata0"}, o_req0_rdata, e.data);
    if (e.id == 1) chk({tag, " rdata1"}, o_req1_rdata, e.data);
  endtask

  // One request cycle plus its response cycle; g is the expected grant
  task automatic step(input logic v0, input logic [AW-1:0] a0,
                      input logic v1, input logic [AW-1:0] a1,
                      input int g, input string tag);
    exp_t e;
    i_req0_valid = v0;
    i_req0_addr  = a0;
    i_req1_valid = v1;
    i_req1_addr  = a1;
    #1;
    chk({tag, " ready0"}, 32'(o_req0_ready), 32'(g == 0));
    chk({tag, " ready1"}, 32'(o_req1_ready), 32'(g == 1));
    if (g == 0) hold = a0;
    else if (g == 1) hold = a1;
    chk({tag, " rom_addr"}, 32'(o_rom_addr), 32'(hold));
    e.id   = g;
    e.data = mem[hold];
    sbq.push_back(e);
    @(posedge i_clk);
    #1;
    e = sbq.pop_front();
    check_resp(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    mem[5] = 32'hDEAD_BEEF;
    hold         = '0;
    i_req0_valid = 1'b1;
    i_req0_addr  = AW'(10);
    i_req1_valid = 1'b1;
    i_req1_addr  = AW'(20);

    @(posedge i_clk);
    #1;
    chk("reset ready0", 32'(o_req0_ready), 32'd0);
    chk("reset ready1", 32'(o_req1_ready), 32'd0);
    chk("reset rvalid0", 32'(o_req0_rvalid), 32'd0);
    chk("reset rvalid1", 32'(o_req1_rvalid), 32'd0);
    chk("reset rom_addr", 32'(o_rom_addr), 32'd0);
    i_rst = 1'b0;

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    step(1'b1, AW'(10), 1'b1, AW'(20), 0, "rr c0");
    step(1'b1, AW'(10), 1'b1, AW'(20), 1, "rr c1");
    step(1'b1, AW'(10), 1'b1, AW'(20), 0, "rr c2");
    step(1'b1, AW'(10), 1'b1, AW'(20), 1, "rr c3");
    step(1'b1, AW'(10), 1'b0, AW'(20), 0, "rr sole0");
`else
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(10), 1'b1, AW'(20), 0, "fp cont");
    step(1'b0, AW'(10), 1'b1, AW'(20), 1, "fp drop0");
`endif

    step(1'b1, AW'(5), 1'b0, AW'(0), 0, "word5");
    step(1'b0, AW'(0), 1'b1, AW'(30), 1, "sole1");

    step(1'b1, AW'(7), 1'b0, AW'(0), 0, "addr7");
    for (int i = 0; i < 5; i++)
      step(1'b0, AW'(9), 1'b0, AW'(11), GNONE, "idle hold");

    i_req0_valid = 1'b0;
    i_req1_valid = 1'b1;
    i_req1_addr  = AW'(3);
    #1;
    chk("rst grant ready1", 32'(o_req1_ready), 32'd1);
    chk("rst grant ready0", 32'(o_req0_ready), 32'd0);
    chk("rst grant rom_addr", 32'(o_rom_addr), 32'd3);
    hold   = AW'(3);
    e.id   = 1;
    e.data = mem[3];
    sbq.push_back(e);
    @(posedge i_clk);
    #1;
    e = sbq.pop_front();
    check_resp("rst resp", e);
    #2;
    i_rst        = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    chk("rst async rvalid1", 32'(o_req1_rvalid), 32'd0);
    chk("rst async rvalid0", 32'(o_req0_rvalid), 32'd0);
    chk("rst async ready0", 32'(o_req0_ready), 32'd0);
    chk("rst async ready1", 32'(o_req1_ready), 32'd0);
    chk("rst async rom_addr", 32'(o_rom_addr), 32'd0);
    @(posedge i_clk);
    #1;
    chk("rst hold rvalid1", 32'(o_req1_rvalid), 32'd0);
    chk("rst hold ready0", 32'(o_req0_ready), 32'd0);
    i_rst = 1'b0;
    hold  = '0;

    step(1'b0, AW'(4), 1'b0, AW'(6), GNONE, "post rst idle");
    step(1'b1, AW'(1), 1'b1, AW'(2), 0, "post rst cont");
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    step(1'b1, AW'(1), 1'b1, AW'(2), 1, "post rst cont2");
`else
    step(1'b1, AW'(1), 1'b1, AW'(2), 0, "post rst cont2");
`endif
    step(1'b0, AW'(1), 1'b0, AW'(2), GNONE, "tail idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
